sine_rom: RTL and testbench



---
 rtl/sine_pkg.sv | 40 ++++
 rtl/sine_rom.sv | 43 ++++
 tb/tb_sine_rom.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/sine_pkg.sv
// Shared constants for the 64x8 sine lookup feeding the DAC sample path.
// The table holds one full period of an unsigned offset-binary sine:
//   TABLE[k] = floor(127.5 + 127.5*sin(2*pi*k/64) + 0.5)
// The values are literal constants, so no real arithmetic is needed at elaboration.
package sine_pkg;

  localparam int unsigned SINE_ADDR_W = 6;
  localparam int unsigned SINE_DATA_W = 8;
  localparam int unsigned SINE_DEPTH  = 2 ** SINE_ADDR_W;

  typedef logic [SINE_ADDR_W-1:0] sine_addr_t;
  typedef logic [SINE_DATA_W-1:0] sine_data_t;

  // One full period, eight samples per row. Quarter points: 0 -> 128, 16 -> 255,
  // 32 -> 128, 48 -> 0. Each half-wave is mirror-symmetric about its peak.
  localparam sine_data_t SINE_TABLE [SINE_DEPTH] = '{
    // k = 0..7
    8'd128, 8'd140, 8'd152, 8'd165, 8'd176, 8'd188, 8'd198, 8'd208,
    // k = 8..15
    8'd218, 8'd226, 8'd234, 8'd240, 8'd245, 8'd250, 8'd253, 8'd254,
    // k = 16..23
    8'd255, 8'd254, 8'd253, 8'd250, 8'd245, 8'd240, 8'd234, 8'd226,
    // k = 24..31
    8'd218, 8'd208, 8'd198, 8'd188, 8'd176, 8'd165, 8'd152, 8'd140,
    // k = 32..39
    8'd128, 8'd115, 8'd103, 8'd90,  8'd79,  8'd67,  8'd57,  8'd47,
    // k = 40..47
    8'd37,  8'd29,  8'd21,  8'd15,  8'd10,  8'd5,   8'd2,   8'd1,
    // k = 48..55
    8'd0,   8'd1,   8'd2,   8'd5,   8'd10,  8'd15,  8'd21,  8'd29,
    // k = 56..63
    8'd37,  8'd47,  8'd57,  8'd67,  8'd79,  8'd90,  8'd103, 8'd115
  };

  // Single-entry accessor so every consumer reads the table the same way.
  function automatic sine_data_t sine_lookup(input sine_addr_t idx);
    return SINE_TABLE[idx];
  endfunction

endpackage : sine_pkg

// File: rtl/sine_rom.sv
// Registered 64x8 sine ROM with read enable.
// A new sample is captured on each rising clka edge with ena=1; ena=0 holds the
// last sample. The 6-bit address covers the whole table, so a free-running
// upstream counter wrapping 63 -> 0 yields a continuous waveform.
module sine_rom
  import sine_pkg::*;
#(
  parameter int unsigned ADDR_W = SINE_ADDR_W,
  parameter int unsigned DATA_W = SINE_DATA_W
) (
  input  logic              clka,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [ADDR_W-1:0] addra,
  output logic [DATA_W-1:0] douta
);

  logic [DATA_W-1:0] douta_d;
  logic [DATA_W-1:0] douta_q;

  // Next sample: table lookup when enabled, otherwise keep the current sample.
  always_comb begin
    // NOTE: default to the held value first so no path leaves douta_d unassigned (no latch).
    douta_d = douta_q;
    if (ena) begin
      douta_d = sine_lookup(addra);
    end
  end

  // Output register with asynchronous clear; reset wins over a same-cycle read.
  // NOTE: only the output register is reset; the table is constant logic and has no state to clear.
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: non-blocking assignment for every flop update, so all registers sample pre-edge values.
      douta_q <= '0;
    end else begin
      douta_q <= douta_d;
    end
  end

  assign douta = douta_q;

endmodule : sine_rom

// File: tb/tb_sine_rom.sv
// Self-checking bench for sine_rom: reset, latency, directed table vectors,
// full sweep against a floating-point model, hold, wrap and table symmetry.
module tb_sine_rom;
  import sine_pkg::*;

  localparam real PI = 3.14159265358979323846;

  logic       clka;
  logic       rst_n;
  logic       ena;
  logic [5:0] addra;
  logic [7:0] douta;

  int n_checks = 0;
  int n_errors = 0;

  sine_rom dut (
    .clka  (clka),
    .rst_n (rst_n),
    .ena   (ena),
    .addra (addra),
    .douta (douta)
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  typedef struct {
    logic       ena;
    logic [5:0] addr;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [16];

  // Independent reference: the defining formula evaluated in real arithmetic.
  function automatic logic [7:0] model(input int k);
    real s;
    s = $sin(2.0 * PI * real'(k) / 64.0);
    return 8'(int'($floor(127.5 + 127.5 * s + 0.5)));
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are stable 1 time unit later.
  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  initial begin
    // Directed vectors: expected value is douta after the edge that applies the row.
    vecs[0]  = '{1'b1, 6'd0,  8'd128};
    vecs[1]  = '{1'b1, 6'd4,  8'd176};
    vecs[2]  = '{1'b1, 6'd8,  8'd218};
    vecs[3]  = '{1'b1, 6'd16, 8'd255};
    vecs[4]  = '{1'b1, 6'd24, 8'd218};
    vecs[5]  = '{1'b1, 6'd32, 8'd128};
    vecs[6]  = '{1'b1, 6'd40, 8'd37};
    vecs[7]  = '{1'b1, 6'd48, 8'd0};
    vecs[8]  = '{1'b1, 6'd56, 8'd37};
    vecs[9]  = '{1'b0, 6'd5,  8'd37};
    vecs[10] = '{1'b0, 6'd63, 8'd37};
    vecs[11] = '{1'b1, 6'd47, 8'd1};
    vecs[12] = '{1'b1, 6'd45, 8'd5};
    vecs[13] = '{1'b1, 6'd13, 8'd250};
    vecs[14] = '{1'b1, 6'd33, 8'd115};
    vecs[15] = '{1'b1, 6'd1,  8'd140};

    // Reset state
    rst_n = 1'b0;
    ena   = 1'b0;
    addra = 6'd0;
    #12;
    check("reset_value", douta, 8'd0);
    rst_n = 1'b1;
    tick();
    check("hold_zero_after_release", douta, 8'd0);

    // Latency: prior value visible before the edge, new sample after it
    ena   = 1'b1;
    addra = 6'd16;
    #2;
    check("latency_before_edge", douta, 8'd0);
    tick();
    check("latency_after_edge", douta, 8'd255);

    // Asynchronous reset mid-stream with an enabled read pending
    addra = 6'd16;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_immediate", douta, 8'd0);
    tick();
    check("reset_overrides_read", douta, 8'd0);
    #1;
    rst_n = 1'b1;
    tick();
    check("first_read_after_reset", douta, 8'd255);

    // Directed table
    for (int i = 0; i < 16; i++) begin
      ena   = vecs[i].ena;
      addra = vecs[i].addr;
      tick();
      check($sformatf("vec%0d_addr%0d", i, vecs[i].addr), douta, vecs[i].exp);
    end

    // Full sweep, back-to-back reads against the formula
    ena = 1'b1;
    for (int k = 0; k < 64; k++) begin
      addra = 6'(k);
      tick();
      check($sformatf("sweep_k%0d", k), douta, model(k));
    end

    // Hold: read 218 then disable with a scrambled address
    ena   = 1'b1;
    addra = 6'd8;
    tick();
    check("hold_load", douta, 8'd218);
    ena = 1'b0;
    for (int c = 0; c < 10; c++) begin
      addra = 6'($urandom_range(0, 63));
      tick();
      check($sformatf("hold_cycle%0d", c), douta, 8'd218);
    end

    // Wrap 62 -> 63 -> 0 -> 1 gives a continuous waveform (values from the formula)
    ena = 1'b1;
    addra = 6'd62; tick(); check("wrap_62", douta, 8'd103);
    addra = 6'd63; tick(); check("wrap_63", douta, 8'd115);
    addra = 6'd0;  tick(); check("wrap_0",  douta, 8'd128);
    addra = 6'd1;  tick(); check("wrap_1",  douta, 8'd140);

    // Symmetry of the package table about each peak
    for (int i = 1; i <= 15; i++) begin
      check($sformatf("sym_hi_%0d", i), SINE_TABLE[16 - i], SINE_TABLE[16 + i]);
      check($sformatf("sym_lo_%0d", i), SINE_TABLE[48 - i], SINE_TABLE[48 + i]);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_sine_rom
